// File: rtl/data_mem_responder_if.sv
// Load/store request and response channel between the memory stage (master)
// and the data-memory responder (slave).
interface data_mem_responder_if;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic [1:0]  ReqSize;
    logic        ReqUnsigned;
    logic        RspValid;
    logic        RspReady;
    logic [31:0] RspRData;
    logic        RspErr;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, ReqSize, ReqUnsigned, RspReady,
        input  ReqReady, RspValid, RspRData, RspErr
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, ReqSize, ReqUnsigned, RspReady,
        output ReqReady, RspValid, RspRData, RspErr
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding byte/half/word data-memory responder with fixed latency.
// Optional misaligned-access error reporting: define DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  io_bus
);
    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam bit         DIRECT   = (LATENCY == 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic             w_do_access;
    logic             w_from_req;
    logic             w_write;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;
    logic [1:0]       w_size;
    logic             w_unsigned;
    logic             w_is_word;
    logic             w_is_half;
    logic [1:0]       w_lane;
    logic [3:0]       w_be;
    logic [31:0]      w_wlane;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_word;
    logic [31:0]      w_shift;
    logic [31:0]      w_load;
    logic             w_err;
    logic             w_unused;

    assign w_accept    = io_bus.ReqValid && r_req_ready;
    assign w_do_access = ((r_state == ST_WAIT) && (r_cnt == 4'd0)) || (DIRECT && w_accept);

    // With LATENCY=1 the access happens on the accept edge, so operands come straight from the bus.
    assign w_from_req = (r_state == ST_IDLE);
    assign w_write    = w_from_req ? io_bus.ReqWrite    : r_write;
    assign w_addr     = w_from_req ? io_bus.ReqAddr     : r_addr;
    assign w_wdata    = w_from_req ? io_bus.ReqWData    : r_wdata;
    assign w_size     = w_from_req ? io_bus.ReqSize     : r_size;
    assign w_unsigned = w_from_req ? io_bus.ReqUnsigned : r_unsigned;

    assign w_is_word = w_size[1];
    assign w_is_half = (w_size == 2'b01);
    assign w_idx     = w_addr[IDX_W+1:2];
    assign w_lane    = w_is_word ? 2'b00 : (w_is_half ? {w_addr[1], 1'b0} : w_addr[1:0]);
    assign w_be      = w_is_word ? 4'b1111 : (w_is_half ? (4'b0011 << w_lane) : (4'b0001 << w_lane));
    assign w_unused  = ^{w_addr[31:IDX_W+2]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_err = (w_is_half && w_addr[0]) || (w_is_word && (w_addr[1:0] != 2'b00));
`else
    assign w_err = 1'b0;
`endif

    // Replicate the low lanes of the store data so every enabled lane sees its bytes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
            assign w_wlane[gi*8 +: 8] = w_is_word ? w_wdata[gi*8 +: 8] :
                                        w_is_half ? w_wdata[(gi%2)*8 +: 8] : w_wdata[7:0];
        end
    endgenerate

    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_lane, 3'b000};

    always_comb begin
        w_load = w_word;
        case (w_size)
            2'b00:   w_load = w_unsigned ? {24'd0, w_shift[7:0]}  : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_load = w_unsigned ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_do_access && w_write && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wlane[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_write     <= io_bus.ReqWrite;
                        r_addr      <= io_bus.ReqAddr;
                        r_wdata     <= io_bus.ReqWData;
                        r_size      <= io_bus.ReqSize;
                        r_unsigned  <= io_bus.ReqUnsigned;
                        r_cnt       <= CNT_INIT;
                        r_req_ready <= 1'b0;
                        r_state     <= DIRECT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= ST_RESP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                ST_RESP: begin
                    if (io_bus.RspReady) begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_do_access) begin
                r_rdata <= (w_err || w_write) ? 32'd0 : w_load;
                r_err   <= w_err;
            end
        end
    end

    assign io_bus.ReqReady = r_req_ready;
    assign io_bus.RspValid = (r_state == ST_RESP);
    assign io_bus.RspRData = r_rdata;
    assign io_bus.RspErr   = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: LATENCY=2 responder for data paths, LATENCY=4 responder for reset mid-wait.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst;
    logic rst4;
    always #5 clk = ~clk;

    data_mem_responder_if bus ();
    data_mem_responder_if bus4 ();

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .io_bus(bus)
    );
    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst4), .io_bus(bus4)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic set_req(input bit d4, input bit v, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input bit uns);
        if (d4) begin
            bus4.ReqValid = v; bus4.ReqWrite = wr; bus4.ReqAddr = addr;
            bus4.ReqWData = wdata; bus4.ReqSize = size; bus4.ReqUnsigned = uns;
        end else begin
            bus.ReqValid = v; bus.ReqWrite = wr; bus.ReqAddr = addr;
            bus.ReqWData = wdata; bus.ReqSize = size; bus.ReqUnsigned = uns;
        end
    endtask

    // One complete request/response; lat = edges from accept edge to first RspValid.
    task automatic xact(input bit d4, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input bit uns,
                        output logic [31:0] rdata, output logic err, output int lat);
        int n;
        rdata = 32'hxxxxxxxx; err = 1'bx; lat = -1;
        @(negedge clk);
        set_req(d4, 1'b1, wr, addr, wdata, size, uns);
        n = 0;
        while (!(d4 ? bus4.ReqReady : bus.ReqReady) && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: ReqReady stayed %b, required 1", 1'b0);
            set_req(d4, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
            return;
        end
        @(negedge clk);
        set_req(d4, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        n = 0;
        while (!(d4 ? bus4.RspValid : bus.RspValid) && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            vectors++; miscompares++;
            $display("FAIL rsp_timeout: RspValid stayed %b, required 1", 1'b0);
            return;
        end
        lat   = n;
        rdata = d4 ? bus4.RspRData : bus.RspRData;
        err   = d4 ? bus4.RspErr   : bus.RspErr;
        if (d4) bus4.RspReady = 1'b1; else bus.RspReady = 1'b1;
        @(negedge clk);
        if (d4) bus4.RspReady = 1'b0; else bus.RspReady = 1'b0;
        $display("xact dut%0d %s addr=%h wdata=%h size=%0d uns=%0d -> rdata=%h err=%0d lat=%0d",
                 d4 ? 4 : 2, wr ? "ST" : "LD", addr, wdata, size, uns, rdata, err, lat);
    endtask

    task automatic test_reset();
        rst = 1'b0; rst4 = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        bus.RspReady = 1'b0; bus4.RspReady = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (bus.ReqReady !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready: got %b want 0", bus.ReqReady); end
        vectors++; if (bus.RspValid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 0", bus.RspValid); end
        vectors++; if (bus.RspRData !== 32'd0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", bus.RspRData); end
        vectors++; if (bus.RspErr !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", bus.RspErr); end
        vectors++; if (bus4.ReqReady !== 1'b0) begin miscompares++; $display("FAIL rst4_req_ready: got %b want 0", bus4.ReqReady); end
        rst = 1'b1; rst4 = 1'b1;
        @(negedge clk);
        vectors++; if (bus.ReqReady !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready: got %b want 1", bus.ReqReady); end
    endtask

    task automatic test_word();
        logic [31:0] d; logic e; int lat;
        xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, d, e, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL st_latency: got %0d want 2", lat); end
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL st_rdata: got %h want 00000000", d); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL st_err: got %b want 0", e); end
        xact(1'b0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, d, e, lat);
        vectors++; if (d !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ld_word: got %h want deadbeef", d); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL ld_latency: got %0d want 2", lat); end
    endtask

    task automatic test_byte();
        logic [31:0] d; logic e; int lat;
        xact(1'b0, 1'b1, 32'h20, 32'h44332211, 2'b10, 1'b0, d, e, lat);
        xact(1'b0, 1'b1, 32'h21, 32'h12345680, 2'b00, 1'b0, d, e, lat);
        xact(1'b0, 1'b0, 32'h21, 32'd0, 2'b00, 1'b0, d, e, lat);
        vectors++; if (d !== 32'hFFFFFF80) begin miscompares++; $display("FAIL ld_byte_s: got %h want ffffff80", d); end
        xact(1'b0, 1'b0, 32'h21, 32'd0, 2'b00, 1'b1, d, e, lat);
        vectors++; if (d !== 32'h00000080) begin miscompares++; $display("FAIL ld_byte_u: got %h want 00000080", d); end
        xact(1'b0, 1'b0, 32'h23, 32'd0, 2'b00, 1'b0, d, e, lat);
        vectors++; if (d !== 32'h00000044) begin miscompares++; $display("FAIL ld_byte_lane3: got %h want 00000044", d); end
        xact(1'b0, 1'b0, 32'h20, 32'd0, 2'b10, 1'b0, d, e, lat);
        vectors++; if (d !== 32'h44338011) begin miscompares++; $display("FAIL byte_merge: got %h want 44338011", d); end
    endtask

    task automatic test_half();
        logic [31:0] d; logic e; int lat;
        xact(1'b0, 1'b1, 32'h30, 32'hAABBCCDD, 2'b10, 1'b0, d, e, lat);
        xact(1'b0, 1'b1, 32'h32, 32'hABCD8001, 2'b01, 1'b0, d, e, lat);
        xact(1'b0, 1'b0, 32'h32, 32'd0, 2'b01, 1'b0, d, e, lat);
        vectors++; if (d !== 32'hFFFF8001) begin miscompares++; $display("FAIL ld_half_s: got %h want ffff8001", d); end
        xact(1'b0, 1'b0, 32'h32, 32'd0, 2'b01, 1'b1, d, e, lat);
        vectors++; if (d !== 32'h00008001) begin miscompares++; $display("FAIL ld_half_u: got %h want 00008001", d); end
        xact(1'b0, 1'b0, 32'h30, 32'd0, 2'b01, 1'b0, d, e, lat);
        vectors++; if (d !== 32'hFFFFCCDD) begin miscompares++; $display("FAIL ld_half_lo: got %h want ffffccdd", d); end
        xact(1'b0, 1'b0, 32'h30, 32'd0, 2'b11, 1'b1, d, e, lat);
        vectors++; if (d !== 32'h8001CCDD) begin miscompares++; $display("FAIL half_merge: got %h want 8001ccdd", d); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic e; int lat; int n;
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0);
        @(negedge clk);
        // Competing store held on the bus while the load is in flight and stalled.
        set_req(1'b0, 1'b1, 1'b1, 32'h10, 32'h0BADF00D, 2'b10, 1'b0);
        n = 0;
        while (!bus.RspValid && n < 50) begin @(negedge clk); n++; end
        vectors++; if (n >= 50) begin miscompares++; $display("FAIL bp_rsp_timeout: RspValid got 0 want 1"); end
        for (int c = 0; c < 5; c++) begin
            vectors++; if (bus.RspValid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b want 1", c, bus.RspValid); end
            vectors++; if (bus.RspRData !== 32'hDEADBEEF) begin miscompares++; $display("FAIL bp_rdata[%0d]: got %h want deadbeef", c, bus.RspRData); end
            vectors++; if (bus.ReqReady !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready[%0d]: got %b want 0", c, bus.ReqReady); end
            @(negedge clk);
        end
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        bus.RspReady = 1'b1;
        @(negedge clk);
        bus.RspReady = 1'b0;
        $display("xact dut2 LD addr=00000010 held 5 cycles under backpressure, released");
        vectors++; if (bus.ReqReady !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", bus.ReqReady); end
        vectors++; if (bus.RspValid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %b want 0", bus.RspValid); end
        xact(1'b0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, d, e, lat);
        vectors++; if (d !== 32'hDEADBEEF) begin miscompares++; $display("FAIL bp_ignored_store: got %h want deadbeef", d); end
    endtask

    task automatic test_wrap();
        logic [31:0] d; logic e; int lat;
        xact(1'b0, 1'b1, 32'h1000, 32'h12345678, 2'b10, 1'b0, d, e, lat);
        xact(1'b0, 1'b0, 32'h0000, 32'd0, 2'b10, 1'b0, d, e, lat);
        vectors++; if (d !== 32'h12345678) begin miscompares++; $display("FAIL wrap: got %h want 12345678", d); end
    endtask

    task automatic test_align();
        logic [31:0] d; logic e; int lat;
        xact(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 2'b10, 1'b0, d, e, lat);
        xact(1'b0, 1'b0, 32'h42, 32'd0, 2'b10, 1'b0, d, e, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL mis_ld_err: got %b want 1", e); end
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL mis_ld_data: got %h want 0", d); end
`else
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL mis_ld_err: got %b want 0", e); end
        vectors++; if (d !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mis_ld_data: got %h want cafef00d", d); end
`endif
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL mis_latency: got %0d want 2", lat); end
        xact(1'b0, 1'b1, 32'h43, 32'h00001234, 2'b01, 1'b0, d, e, lat);
        xact(1'b0, 1'b0, 32'h40, 32'd0, 2'b10, 1'b0, d, e, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        vectors++; if (d !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mis_st_blocked: got %h want cafef00d", d); end
`else
        vectors++; if (d !== 32'h1234F00D) begin miscompares++; $display("FAIL mis_st_forced: got %h want 1234f00d", d); end
`endif
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] d; logic e; int lat;
        xact(1'b1, 1'b1, 32'h40, 32'h11111111, 2'b10, 1'b0, d, e, lat);
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL lat4: got %0d want 4", lat); end
        xact(1'b1, 1'b0, 32'h40, 32'd0, 2'b10, 1'b0, d, e, lat);
        vectors++; if (d !== 32'h11111111) begin miscompares++; $display("FAIL lat4_ld: got %h want 11111111", d); end
        @(negedge clk);
        set_req(1'b1, 1'b1, 1'b1, 32'h40, 32'h22222222, 2'b10, 1'b0);
        @(negedge clk);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        @(negedge clk);
        rst4 = 1'b0;
        #1;
        $display("xact dut4 ST addr=00000040 wdata=22222222 interrupted by reset in wait");
        vectors++; if (bus4.RspRData !== 32'd0) begin miscompares++; $display("FAIL midrst_rdata: got %h want 0", bus4.RspRData); end
        vectors++; if (bus4.RspValid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", bus4.RspValid); end
        vectors++; if (bus4.ReqReady !== 1'b0) begin miscompares++; $display("FAIL midrst_ready: got %b want 0", bus4.ReqReady); end
        repeat (2) @(negedge clk);
        rst4 = 1'b1;
        repeat (6) @(negedge clk);
        vectors++; if (bus4.RspValid !== 1'b0) begin miscompares++; $display("FAIL midrst_no_rsp: got %b want 0", bus4.RspValid); end
        xact(1'b1, 1'b0, 32'h40, 32'd0, 2'b10, 1'b0, d, e, lat);
        vectors++; if (d !== 32'h11111111) begin miscompares++; $display("FAIL midrst_dropped: got %h want 11111111", d); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_backpressure();
        test_wrap();
        test_align();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
